example_syn_core: RTL and testbench

//  Registered 3-input single-output Boolean function unit with valid tracking.

---
 rtl/example_syn_pkg.sv | 12 +
 rtl/example_syn_if.sv | 41 ++++
 rtl/example_syn_lut.sv | 12 +
 rtl/example_syn_core.sv | 86 ++++++++
 tb/tb_example_syn_core.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/example_syn_pkg.sv
// rtl/example_syn_pkg.sv - shared constants and types for the example_syn function unit
package example_syn_pkg;

  localparam int IDX_W = 3;
  localparam int TT_W = 2 ** IDX_W;

  // F = ~C & ~(A & B): minterms 000, 010, 100
  localparam logic [TT_W-1:0] TT_DEFAULT = 8'b0001_0101;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/example_syn_if.sv
// rtl/example_syn_if.sv - evaluation/coverage bus; lut_we/lut_data present only with EXAMPLE_SYN_LUT_EN
interface example_syn_if #(
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             a;
  logic             b;
  logic             c;
  logic             cov_clr;
  logic             f;
  logic             out_valid;
  logic [7:0]       cov;
  logic [CNT_W-1:0] eval_cnt;

`ifdef EXAMPLE_SYN_LUT_EN
  logic             lut_we;
  logic [7:0]       lut_data;

  modport master (
    output in_valid, a, b, c, cov_clr, lut_we, lut_data,
    input  f, out_valid, cov, eval_cnt
  );

  modport slave (
    input  in_valid, a, b, c, cov_clr, lut_we, lut_data,
    output f, out_valid, cov, eval_cnt
  );
`else
  modport master (
    output in_valid, a, b, c, cov_clr,
    input  f, out_valid, cov, eval_cnt
  );

  modport slave (
    input  in_valid, a, b, c, cov_clr,
    output f, out_valid, cov, eval_cnt
  );
`endif

endinterface

// File: rtl/example_syn_lut.sv
// rtl/example_syn_lut.sv - combinational 8:1 truth-table lookup
module example_syn_lut
  import example_syn_pkg::*;
(
  input  idx_t            idx,
  input  logic [TT_W-1:0] tt,
  output logic            f
);

  assign f = tt[idx];

endmodule

// File: rtl/example_syn_core.sv
// rtl/example_syn_core.sv - 2-stage registered Boolean function unit with coverage; EXAMPLE_SYN_LUT_EN adds a loadable table
module example_syn_core #(
  parameter logic [7:0] TT_DEFAULT = example_syn_pkg::TT_DEFAULT,
  parameter int         CNT_W      = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  example_syn_if.slave  bus
);

  import example_syn_pkg::*;

  idx_t             s1_idx;
  logic             s1_vld;
  logic [TT_W-1:0]  tt;
  logic             lut_f;
  logic             f_q;
  logic             ov_q;
  logic [TT_W-1:0]  cov_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef EXAMPLE_SYN_LUT_EN
  // Stage 2 reads tt before this edge's load lands, so a coinciding evaluation sees the old table
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt <= TT_DEFAULT;
    end else if (bus.lut_we) begin
      tt <= bus.lut_data;
    end
  end
`else
  assign tt = TT_DEFAULT;
`endif

  example_syn_lut u_lut (
    .idx (s1_idx),
    .tt  (tt),
    .f   (lut_f)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_idx <= '0;
    end else begin
      s1_vld <= bus.in_valid;
      if (bus.in_valid) begin
        s1_idx <= {bus.a, bus.b, bus.c};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_q  <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      ov_q <= s1_vld;
      if (s1_vld) begin
        f_q <= lut_f;
      end
    end
  end

  // Clear takes priority over an evaluation retiring in the same cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cov_q <= '0;
      cnt_q <= '0;
    end else if (bus.cov_clr) begin
      cov_q <= '0;
      cnt_q <= '0;
    end else if (s1_vld) begin
      cov_q[s1_idx] <= 1'b1;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.f         = f_q;
  assign bus.out_valid = ov_q;
  assign bus.cov       = cov_q;
  assign bus.eval_cnt  = cnt_q;

endmodule

// File: tb/tb_example_syn_core.sv
// tb/tb_example_syn_core.sv - directed self-checking bench for example_syn_core
module tb_example_syn_core;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic last_f;

  // F for idx = {A,B,C} 0..7, worked out by hand from ~C & ~(A & B)
  int fexp[8] = '{1, 0, 1, 0, 1, 0, 0, 0};
  int pv[10]  = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0};
  int ix[10]  = '{1, 0, 0, 4, 2, 0, 3, 0, 0, 0};

  example_syn_if #(.CNT_W(8)) bus ();

  example_syn_core #(.CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx);
    logic [2:0] i3;
    i3 = 3'(idx);
    bus.in_valid = v;
    {bus.a, bus.b, bus.c} = i3;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    bus.cov_clr = 1'b0;
`ifdef EXAMPLE_SYN_LUT_EN
    bus.lut_we   = 1'b0;
    bus.lut_data = 8'h00;
`endif
    drive(1'b0, 0);
    tick();
    tick();
    check_eq("rst_f", 32'(bus.f), 0);
    check_eq("rst_ov", 32'(bus.out_valid), 0);
    check_eq("rst_cov", 32'(bus.cov), 0);
    check_eq("rst_cnt", 32'(bus.eval_cnt), 0);
    rst_n = 1'b1;

    // Sweep 000..111, results from the second edge on
    for (int i = 0; i < 10; i++) begin
      drive(i < 8, i % 8);
      tick();
      if (i == 0) check_eq("sweep_ov_lat", 32'(bus.out_valid), 0);
      if (i >= 1 && i <= 8) begin
        check_eq($sformatf("sweep_f%0d", i - 1), 32'(bus.f), 32'(fexp[i-1]));
        check_eq($sformatf("sweep_ov%0d", i - 1), 32'(bus.out_valid), 1);
      end
    end
    check_eq("sweep_ov_end", 32'(bus.out_valid), 0);
    check_eq("sweep_cov", 32'(bus.cov), 32'h0ff);
    check_eq("sweep_cnt", 32'(bus.eval_cnt), 8);

    // Gapped valids: out_valid trails in_valid by 2, f holds through gaps
    last_f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(pv[i] != 0, ix[i]);
      tick();
      if (i >= 1) begin
        if (pv[i-1] != 0) last_f = (fexp[ix[i-1]] != 0);
        check_eq($sformatf("gap_ov%0d", i), 32'(bus.out_valid), 32'(pv[i-1]));
        check_eq($sformatf("gap_f%0d", i), 32'(bus.f), 32'(last_f));
      end
    end

    // Reset mid-sweep
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i);
      tick();
    end
    rst_n = 1'b0;
    drive(1'b1, 4);
    tick();
    check_eq("mrst_f", 32'(bus.f), 0);
    check_eq("mrst_ov", 32'(bus.out_valid), 0);
    check_eq("mrst_cov", 32'(bus.cov), 0);
    check_eq("mrst_cnt", 32'(bus.eval_cnt), 0);
    rst_n = 1'b1;
    drive(1'b1, 2);
    tick();
    check_eq("mrst_ov_flush", 32'(bus.out_valid), 0);
    drive(1'b0, 0);
    tick();
    check_eq("mrst_f2", 32'(bus.f), 1);
    check_eq("mrst_ov2", 32'(bus.out_valid), 1);
    check_eq("mrst_cov2", 32'(bus.cov), 32'h04);
    check_eq("mrst_cnt2", 32'(bus.eval_cnt), 1);

    // Clear coinciding with a stage-2 evaluation of idx 0
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    bus.cov_clr = 1'b1;
    tick();
    bus.cov_clr = 1'b0;
    check_eq("clr_cov", 32'(bus.cov), 0);
    check_eq("clr_cnt", 32'(bus.eval_cnt), 0);
    check_eq("clr_f", 32'(bus.f), 1);
    check_eq("clr_ov", 32'(bus.out_valid), 1);
    drive(1'b1, 5);
    tick();
    drive(1'b0, 0);
    tick();
    check_eq("clr_cov5", 32'(bus.cov), 32'h20);
    check_eq("clr_cnt5", 32'(bus.eval_cnt), 1);
    check_eq("clr_f5", 32'(bus.f), 0);

    // Saturation: 255 then 45 more evaluations
    bus.cov_clr = 1'b1;
    tick();
    bus.cov_clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive(1'b1, i % 8);
      tick();
    end
    drive(1'b0, 0);
    tick();
    tick();
    check_eq("sat_255", 32'(bus.eval_cnt), 255);
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, i % 8);
      tick();
    end
    drive(1'b0, 0);
    tick();
    tick();
    check_eq("sat_300", 32'(bus.eval_cnt), 255);
    check_eq("sat_cov", 32'(bus.cov), 32'h0ff);

`ifdef EXAMPLE_SYN_LUT_EN
    bus.lut_we   = 1'b1;
    bus.lut_data = 8'h80;
    tick();
    bus.lut_we   = 1'b0;
    drive(1'b1, 7);
    tick();
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    check_eq("lut_f7", 32'(bus.f), 1);
    tick();
    check_eq("lut_f0", 32'(bus.f), 0);
    // Load coinciding with evaluation of idx 0 uses the old table (0x80)
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    bus.lut_we   = 1'b1;
    bus.lut_data = 8'h01;
    tick();
    bus.lut_we   = 1'b0;
    check_eq("lut_old", 32'(bus.f), 0);
    drive(1'b1, 0);
    tick();
    drive(1'b0, 0);
    tick();
    check_eq("lut_new", 32'(bus.f), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
